// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: maps the one-hot fan level to a ramped PWM motor drive.
// Latency: o_pwm is registered one clock after counter/duty; duty moves at PWM period ends (off is forced next clock).
// Backpressure: none; counters free-run and the level input is sampled every clock.
// Optional feature macro: KICKSTART_EN (full-duty kick for KICK_PERIODS periods before ramping).
module pwm_ramp_ctrl #(
  parameter int CNT_W        = 8,
  parameter int PRESC        = 4,
  parameter int STEP         = 8,
  parameter int KICK_PERIODS = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [3:0]       i_lightState,
  output logic             o_pwm,
  output logic [CNT_W-1:0] o_duty,
  output logic [1:0]       o_state,
  output logic             o_busy,
  output logic             o_fault
);

  localparam int MAX_I = (1 << CNT_W) - 1;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [CNT_W:0] MAX_D  = (CNT_W+1)'(MAX_I);
  localparam logic [CNT_W:0] STEP_D = (CNT_W+1)'(STEP);
  localparam logic [CNT_W:0] TGT_1  = (CNT_W+1)'((MAX_I + 1) / 4);
  localparam logic [CNT_W:0] TGT_2  = (CNT_W+1)'((MAX_I + 1) / 2);
  localparam logic [CNT_W:0] TGT_3  = (CNT_W+1)'(3 * (MAX_I + 1) / 4);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_KICK = 2'd1;
  localparam logic [1:0] ST_RAMP = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Reject parameter sets that would break the ramp or tick arithmetic.
  if (PRESC < 1 || STEP < 1 || STEP > MAX_I || KICK_PERIODS < 1) begin : g_bad_param
    $error("pwm_ramp_ctrl: illegal parameter combination");
  end

  logic [PW-1:0]    presc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [1:0]       state_q, state_d;
  logic             pwm_q;
  logic             fault_q;

`ifdef KICKSTART_EN
  localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  logic [KW-1:0] kcnt_q, kcnt_d;
`endif

  logic           tick, pe;
  logic           off, illegal;
  logic [CNT_W:0] target;
  logic [CNT_W:0] duty_x, up_sum, dn_diff, stepped;

  assign tick   = (presc_q == PW'(PRESC - 1));
  assign pe     = tick && (cnt_q == CNT_W'(MAX_I - 1));
  assign duty_x = {1'b0, duty_q};

  // Decode the level: 0000 is a hard off, unlisted codes ramp down to zero and flag a fault.
  always_comb begin
    target  = '0;
    off     = 1'b0;
    illegal = 1'b0;
    case (i_lightState)
      4'b0000: off    = 1'b1;
      4'b0001: target = TGT_1;
      4'b0010: target = TGT_2;
      4'b0100: target = TGT_3;
      4'b1000: target = MAX_D;
      default: illegal = 1'b1;
    endcase
  end

  // One ramp step toward target, clamped at target in either direction (one extra bit avoids wrap).
  always_comb begin
    up_sum  = duty_x + STEP_D;
    dn_diff = (duty_x >= STEP_D) ? (duty_x - STEP_D) : '0;
    if (target >= duty_x) begin
      stepped = (up_sum > target) ? target : up_sum;
    end else begin
      stepped = (dn_diff < target) ? target : dn_diff;
    end
  end

  // Mode FSM: hard off wins in every state; otherwise duty only moves on period ends.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
`ifdef KICKSTART_EN
    kcnt_d  = kcnt_q;
`endif
    if (off) begin
      state_d = ST_IDLE;
      duty_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          duty_d = '0;
          if (target != '0) begin
`ifdef KICKSTART_EN
            state_d = ST_KICK;
            kcnt_d  = '0;
`else
            state_d = ST_RAMP;
`endif
          end
        end
`ifdef KICKSTART_EN
        ST_KICK: begin
          if (pe) begin
            duty_d = MAX_D[CNT_W-1:0];
            if (kcnt_q == KW'(KICK_PERIODS - 1)) begin
              state_d = ST_RAMP;
            end else begin
              kcnt_d = kcnt_q + KW'(1);
            end
          end
        end
`endif
        ST_RAMP: begin
          if (pe) begin
            duty_d = stepped[CNT_W-1:0];
            if (stepped == target) begin
              state_d = (target == '0) ? ST_IDLE : ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (target != duty_x) begin
            state_d = ST_RAMP;
          end
        end
        default: begin
          state_d = ST_IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  // Free-running prescaler and PWM period counter.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else if (tick) begin
      presc_q <= '0;
      cnt_q   <= pe ? '0 : cnt_q + CNT_W'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // FSM, duty, registered PWM compare and fault flag.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      pwm_q   <= (cnt_q < duty_q);
      fault_q <= illegal;
    end
  end

`ifdef KICKSTART_EN
  // Kick period counter, only meaningful while in KICK.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      kcnt_q <= '0;
    end else begin
      kcnt_q <= kcnt_d;
    end
  end
`endif

  assign o_pwm   = pwm_q;
  assign o_duty  = duty_q;
  assign o_state = state_q;
  assign o_busy  = (state_q == ST_KICK) || (state_q == ST_RAMP);
  assign o_fault = fault_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with CNT_W=8, PRESC=1, STEP=8 (period = 255 clocks).
// Inputs driven and outputs sampled on the falling edge.
// Build with KICKSTART_EN to exercise the kick-start path instead of the plain ramp tests.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] lvl;
  logic       pwm;
  logic [7:0] duty;
  logic [1:0] state;
  logic       busy;
  logic       fault;

  int n_chk  = 0;
  int n_pass = 0;
  int ref_cnt;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(
    .CNT_W(8), .PRESC(1), .STEP(8), .KICK_PERIODS(16)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_lightState(lvl),
    .o_pwm(pwm),
    .o_duty(duty),
    .o_state(state),
    .o_busy(busy),
    .o_fault(fault)
  );

  // Reference PWM period position: one tick per clock, 255 ticks per period.
  always @(posedge clk) begin
    if (!rst_n) ref_cnt <= 0;
    else        ref_cnt <= (ref_cnt == 254) ? 0 : ref_cnt + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Return on the falling edge just after the next period end.
  task automatic wait_pe();
    for (int i = 0; i < 300; i++) begin
      if (ref_cnt == 254) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pwm"},   int'(pwm),   0);
    chk({tag, "_duty"},  int'(duty),  0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_busy"},  int'(busy),  0);
    chk({tag, "_fault"}, int'(fault), 0);
  endtask

  initial begin
    int exp_d;
    int highs;

    // 1: reset held with a legal nonzero level applied.
    rst_n = 1'b0;
    lvl   = 4'b0100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_reset_outputs($sformatf("t1_rst%0d", i));
    end
    rst_n = 1'b1;
    lvl   = 4'b0000;
    tick_n(3);
    chk("idle_state", int'(state), 0);
    chk("idle_duty",  int'(duty),  0);

`ifndef KICKSTART_EN
    // 2: 0000 -> 0010 ramps up by 8 per period to 128 then holds.
    lvl = 4'b0010;
    @(negedge clk);
    chk("t2_enter_ramp", int'(state), 2);
    chk("t2_busy", int'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      wait_pe();
      chk($sformatf("t2_duty%0d", k), int'(duty), 8 * k);
      chk($sformatf("t2_state%0d", k), int'(state), (k == 16) ? 3 : 2);
    end
    chk("t2_busy_hold", int'(busy), 0);
    highs = 0;
    for (int i = 0; i < 255; i++) begin
      if (pwm) highs++;
      @(negedge clk);
    end
    chk("t2_pwm_highs", highs, 128);

    // 3: 0010 -> 1000 ramps up from 128 and saturates at 255.
    lvl = 4'b1000;
    @(negedge clk);
    chk("t3_enter_ramp", int'(state), 2);
    for (int k = 1; k <= 16; k++) begin
      wait_pe();
      exp_d = (k == 16) ? 255 : 128 + 8 * k;
      chk($sformatf("t3_duty%0d", k), int'(duty), exp_d);
      chk($sformatf("t3_state%0d", k), int'(state), (k == 16) ? 3 : 2);
    end

    // 4: hard off mid-period from HOLD@255.
    for (int i = 0; i < 300; i++) begin
      if (ref_cnt == 100) break;
      @(negedge clk);
    end
    lvl = 4'b0000;
    @(negedge clk);
    chk("t4_off_duty",  int'(duty),  0);
    chk("t4_off_state", int'(state), 0);
    chk("t4_off_busy",  int'(busy),  0);
    @(negedge clk);
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      if (pwm) highs++;
      @(negedge clk);
    end
    chk("t4_pwm_low", highs, 0);

    // 5: ramp to 64, illegal code ramps back down to idle, legal code restarts.
    lvl = 4'b0001;
    @(negedge clk);
    chk("t5_enter_ramp", int'(state), 2);
    for (int k = 1; k <= 8; k++) begin
      wait_pe();
      chk($sformatf("t5_up%0d", k), int'(duty), 8 * k);
    end
    chk("t5_hold64", int'(state), 3);
    lvl = 4'b0110;
    @(negedge clk);
    chk("t5_fault_set", int'(fault), 1);
    chk("t5_ramp_down", int'(state), 2);
    for (int k = 1; k <= 8; k++) begin
      wait_pe();
      chk($sformatf("t5_dn%0d", k), int'(duty), 64 - 8 * k);
      chk($sformatf("t5_dn_state%0d", k), int'(state), (k == 8) ? 0 : 2);
    end
    chk("t5_fault_held", int'(fault), 1);
    lvl = 4'b0001;
    @(negedge clk);
    chk("t5_fault_clr", int'(fault), 0);
    chk("t5_restart", int'(state), 2);
    wait_pe();
    chk("t5_restart_duty", int'(duty), 8);

    // Reset in the middle of a ramp leaves nothing behind.
    lvl = 4'b1000;
    wait_pe();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t5_rst_ramp");
    rst_n = 1'b1;
`else
    // 6: kick-start at full duty for 16 periods, then ramp down to 64.
    lvl = 4'b0001;
    @(negedge clk);
    chk("t6_enter_kick", int'(state), 1);
    chk("t6_busy", int'(busy), 1);
    for (int k = 1; k <= 16; k++) begin
      wait_pe();
      chk($sformatf("t6_kick_duty%0d", k), int'(duty), 255);
      chk($sformatf("t6_kick_state%0d", k), int'(state), (k == 16) ? 2 : 1);
    end
    for (int j = 1; j <= 24; j++) begin
      wait_pe();
      exp_d = (255 - 8 * j < 64) ? 64 : 255 - 8 * j;
      chk($sformatf("t6_dn%0d", j), int'(duty), exp_d);
      chk($sformatf("t6_dn_state%0d", j), int'(state), (j == 24) ? 3 : 2);
    end

    // Reset asserted mid-kick.
    lvl = 4'b0000;
    tick_n(2);
    lvl = 4'b0001;
    @(negedge clk);
    chk("t6_rekick", int'(state), 1);
    for (int k = 0; k < 3; k++) wait_pe();
    tick_n(40);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs("t6_rst_kick");
    rst_n = 1'b1;
`endif

    tick_n(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
